// File: rtl/dm_access_ctrl_if.sv
// Bundle for the two requester ports and the data-memory side of dm_access_ctrl.
// slave = controller view, master = requesters plus memory (testbench) view.
interface dm_access_ctrl_if;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_pc, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic [31:0] dm_A, dm_D_write, dm_D_read, dm_PC;
    logic        dm_WE;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be, m0_pc,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        output m1_ack, m1_rdata, m1_err,
        output dm_A, dm_D_write, dm_WE, dm_PC,
        input  dm_D_read
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be, m0_pc,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        input  m1_ack, m1_rdata, m1_err,
        input  dm_A, dm_D_write, dm_WE, dm_PC,
        output dm_D_read
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Round-robin two-port controller for the word-wide data memory, with
// read-modify-write byte-enable stores and an upper address bound check.
module dm_byte_merge #(
    parameter int VEC_W = 8
) (
    input  logic             i_be,
    input  logic [VEC_W-1:0] i_wdata,
    input  logic [VEC_W-1:0] i_old,
    output logic [VEC_W-1:0] o_byte
);
    assign o_byte = i_be ? i_wdata : i_old;
endmodule

module dm_access_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
    parameter int          NUM_LANES  = 4,
    parameter int          VEC_W      = 8
) (
    input  logic              clk,
    input  logic              RESET,
    dm_access_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_DONE} state_t;

    state_t                               r_state, w_next;
    logic                                 r_rr, r_id, r_we, r_err;
    logic [31:0]                          r_addr, r_wdata, r_pc, r_merge;
    logic [NUM_LANES-1:0]                 r_be;
    logic [1:0][31:0]                     r_rdata;
    logic                                 w_any, w_win, w_oor, w_full, w_none, w_part, w_we;
    logic [NUM_LANES-1:0][VEC_W-1:0]      w_wlanes, w_olanes, w_mlanes;

    assign w_any  = bus.m0_req | bus.m1_req;
    assign w_win  = (bus.m0_req & bus.m1_req) ? r_rr : bus.m1_req;
    assign w_oor  = r_addr >= ADDR_LIMIT;
    assign w_full = &r_be;
    assign w_none = ~|r_be;
    assign w_part = ~w_full & ~w_none;

    assign w_wlanes = r_wdata;
    assign w_olanes = r_merge;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dm_byte_merge #(.VEC_W(VEC_W)) u_merge (
            .i_be    (r_be[g]),
            .i_wdata (w_wlanes[g]),
            .i_old   (w_olanes[g]),
            .o_byte  (w_mlanes[g])
        );
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Write enable is a function of state and latched fields only, so reset kills it at once.
    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_ACCESS;
            S_ACCESS: begin
                w_we   = r_we & ~w_oor & w_full;
                w_next = (r_we & ~w_oor & w_part) ? S_WRITE : S_DONE;
            end
            S_WRITE:  begin
                w_we   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_rr    <= 1'b0;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
            r_merge <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_id    <= w_win;
                    r_rr    <= ~w_win;
                    r_we    <= w_win ? bus.m1_we    : bus.m0_we;
                    r_addr  <= w_win ? bus.m1_addr  : bus.m0_addr;
                    r_wdata <= w_win ? bus.m1_wdata : bus.m0_wdata;
                    r_be    <= w_win ? bus.m1_be    : bus.m0_be;
                    r_pc    <= w_win ? 32'h0        : bus.m0_pc;
                    r_err   <= 1'b0;
                end
                S_ACCESS: begin
                    r_err <= w_oor;
                    if (w_oor)        r_rdata[r_id] <= '0;
                    else if (!r_we)   r_rdata[r_id] <= bus.dm_D_read;
                    else if (w_part)  r_merge       <= bus.dm_D_read;
                end
                default: ;
            endcase
        end
    end

    assign bus.m0_ack     = (r_state == S_DONE) & ~r_id;
    assign bus.m1_ack     = (r_state == S_DONE) &  r_id;
    assign bus.m0_err     = bus.m0_ack & r_err;
    assign bus.m1_err     = bus.m1_ack & r_err;
    assign bus.m0_rdata   = r_rdata[0];
    assign bus.m1_rdata   = r_rdata[1];
    assign bus.dm_A       = {r_addr[31:2], 2'b00};
    assign bus.dm_D_write = (r_state == S_WRITE) ? w_mlanes : r_wdata;
    assign bus.dm_WE      = w_we;
    assign bus.dm_PC      = r_pc;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: tasks push expected acks, a monitor pops and compares.
module tb_dm_access_ctrl;
    logic clk;
    logic RESET;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   we_cnt = 0;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] mem [0:4095];

    typedef struct {
        int          port;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    dm_access_ctrl_if bus();

    dm_access_ctrl #(.ADDR_LIMIT(32'h0000_3000)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the clock edge.
    assign bus.dm_D_read = (bus.dm_A < 32'h3000) ? mem[bus.dm_A[13:2]] : 32'h0;
    always @(posedge clk) if (bus.dm_WE && bus.dm_A < 32'h3000) mem[bus.dm_A[13:2]] <= bus.dm_D_write;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.dm_WE) begin
                we_cnt++;
                last_pc = bus.dm_PC;
            end
            if (bus.m0_ack || bus.m1_ack) begin
                if (bus.m0_ack && bus.m1_ack) chk32("ack_overlap", 32'd1, 32'd0);
                if (sb.size() == 0) begin
                    chk32("unexpected_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk32("ack_port", {31'd0, bus.m1_ack}, e.port);
                    chk32("ack_cycle", cyc, e.cyc);
                    chk32("ack_err", {31'd0, e.port == 1 ? bus.m1_err : bus.m0_err}, {31'd0, e.err});
                    if (e.chk) chk32("rdata", e.port == 1 ? bus.m1_rdata : bus.m0_rdata, e.rdata);
                end
            end
        end
    end

    task automatic xact(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] pc, input int lat,
                        input logic err, input logic chk, input logic [31:0] exp_rd);
        exp_t e;
        int   n;
        @(negedge clk);
        if (p == 0) begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_be = be; bus.m0_pc = pc;
            bus.m0_req = 1'b1;
        end else begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_be = be;
            bus.m1_req = 1'b1;
        end
        e.port = p; e.err = err; e.chk = chk; e.rdata = exp_rd; e.cyc = cyc + lat;
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p == 0 ? bus.m0_ack : bus.m1_ack) && n < 20);
        if (n >= 20) chk32("ack_timeout", 32'd1, 32'd0);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
    endtask

    initial begin
        int w0, n0, n1, k;
        RESET = 1'b1;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_be = 0; bus.m0_pc = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_be = 0;
        repeat (2) @(negedge clk);
        chk32("rst_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        chk32("rst_we", {31'd0, bus.dm_WE}, 32'd0);
        chk32("rst_A", bus.dm_A, 32'h0);
        chk32("rst_PC", bus.dm_PC, 32'h0);
        chk32("rst_rdata0", bus.m0_rdata, 32'h0);
        RESET = 1'b0;

        // Full store then load on port 0.
        w0 = we_cnt;
        xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2, 0, 0, 32'h0);
        chk32("full_we_cycles", we_cnt - w0, 32'd1);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 32'h0, 2, 0, 1, 32'hDEADBEEF);

        // Partial store merges into the existing word.
        xact(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 2, 0, 0, 32'h0);
        w0 = we_cnt;
        xact(0, 1, 32'h20, 32'h0000AA00, 4'b0010, 32'h0, 3, 0, 0, 32'h0);
        chk32("part_we_cycles", we_cnt - w0, 32'd1);
        chk32("part_mem", mem[8], 32'h1122AA44);
        xact(0, 0, 32'h22, 32'h0, 4'h0, 32'h0, 2, 0, 1, 32'h1122AA44);

        // Reset in the middle of a read-modify-write.
        xact(0, 1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 2, 0, 0, 32'h0);
        @(negedge clk);
        bus.m0_we = 1; bus.m0_addr = 32'h30; bus.m0_wdata = 32'h00000055; bus.m0_be = 4'b0001;
        bus.m0_req = 1'b1;
        repeat (2) @(negedge clk);
        chk32("rmw_we_before_rst", {31'd0, bus.dm_WE}, 32'd1);
        RESET = 1'b1;
        bus.m0_req = 1'b0;
        #1;
        chk32("rmw_we_after_rst", {31'd0, bus.dm_WE}, 32'd0);
        @(negedge clk);
        chk32("rmw_mem_kept", mem[12], 32'hCAFEF00D);
        chk32("rmw_no_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        RESET = 1'b0;

        // Both ports saturating from reset: grants 0,1,0,1.
        @(negedge clk);
        bus.m0_we = 0; bus.m0_addr = 32'h10;
        bus.m1_we = 0; bus.m1_addr = 32'h20;
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        sb.push_back('{port:0, err:1'b0, chk:1'b1, rdata:32'hDEADBEEF, cyc:cyc + 2});
        sb.push_back('{port:1, err:1'b0, chk:1'b1, rdata:32'h1122AA44, cyc:cyc + 5});
        sb.push_back('{port:0, err:1'b0, chk:1'b1, rdata:32'hDEADBEEF, cyc:cyc + 8});
        sb.push_back('{port:1, err:1'b0, chk:1'b1, rdata:32'h1122AA44, cyc:cyc + 11});
        n0 = 0; n1 = 0; k = 0;
        while ((n0 < 2 || n1 < 2) && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.m0_ack) begin n0++; if (n0 == 2) bus.m0_req = 1'b0; end
            if (bus.m1_ack) begin n1++; if (n1 == 2) bus.m1_req = 1'b0; end
        end
        if (k >= 40) chk32("contention_timeout", 32'd1, 32'd0);
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;

        // Out-of-range accesses on port 1.
        w0 = we_cnt;
        xact(1, 0, 32'h3000, 32'h0, 4'h0, 32'h0, 2, 1, 1, 32'h0);
        xact(1, 1, 32'h7FFC, 32'h12345678, 4'hF, 32'h0, 2, 1, 0, 32'h0);
        chk32("oor_no_we", we_cnt - w0, 32'd0);
        chk32("oor_port0_rdata_held", bus.m0_rdata, 32'hDEADBEEF);

        // Trace PC and the byte-enable-zero no-op.
        xact(0, 1, 32'h40, 32'h01020304, 4'hF, 32'h3008, 2, 0, 0, 32'h0);
        chk32("pc_port0", last_pc, 32'h3008);
        xact(1, 1, 32'h44, 32'h05060708, 4'hF, 32'h0, 2, 0, 0, 32'h0);
        chk32("pc_port1", last_pc, 32'h0);
        w0 = we_cnt;
        xact(0, 1, 32'h40, 32'hFFFFFFFF, 4'h0, 32'h3008, 2, 0, 0, 32'h0);
        chk32("noop_no_we", we_cnt - w0, 32'd0);
        xact(1, 0, 32'h40, 32'h0, 4'h0, 32'h0, 2, 0, 1, 32'h01020304);

        repeat (3) @(negedge clk);
        chk32("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
